negacyclic_fold_reducer: RTL and testbench
==========================================

// Module: negacyclic_fold_reducer
// PURPOSE
//  Downstream stage of the polynomial multiplier. Captures its 2N-1 coefficient product on the done pulse.
//  Folds the product modulo x^N+1: out[i] = (c[i] - c[i+N]) mod Q, with c[2N-1] taken as 0.
//  Emits N coefficients in [0,Q) through a valid/ready handshake. Computes one coefficient per cycle
//  from a registered capture buffer, so the multiplier array is free for its next operand set.
// PARAMETERS
//  MULTIPLIER_WIDTH  8    N; product has 2N-1 coefficients, output has N
//  INPUT_WIDTH       8    W; bit width of each product and output coefficient
//  MODULUS           251  Q; must satisfy 2^(W-1) < Q < 2^W (elaboration-time check)
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high reset
//  prod_valid  in   1          single-cycle pulse; product coefficients valid (multiplier done)
//  prod_cs     in   (2N-1)*W   packed [2N-2:0][W-1:0] product coefficients
//  in_ready    out  1          block can accept a product this cycle
//  out_valid   out  1          out_coeffs holds a complete folded result
//  out_ready   in   1          downstream accepts result when out_valid && out_ready
//  out_coeffs  out  N*W        packed [N-1:0][W-1:0] reduced coefficients
//  busy        out  1          state != IDLE
//  overflow    out  1          sticky: a prod_valid pulse was dropped
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, idx=0, capture buffer=0, out_coeffs=0, out_valid=0, overflow=0.
//  States: IDLE, FOLD, DONE. Outputs: in_ready = IDLE | (DONE & out_ready); out_valid = DONE.
//  IDLE: prod_valid -> capture prod_cs into buffer, idx<=0, go FOLD.
//  FOLD: each cycle computes out_coeffs[idx] from buffer[idx] and buffer[idx+N], then idx<=idx+1.
//    Buffer index 2N-1 reads as 0. When idx==N-1 the write completes and state goes to DONE; idx wraps to 0.
//  DONE: out_coeffs stable. out_ready -> IDLE, or straight to FOLD with a fresh capture if prod_valid is
//    high in the same cycle (back-to-back accept, no bubble).
//  Latency: accepting edge k; coefficient i written at edge k+1+i; out_valid high after edge k+N.
//  Throughput: with no backpressure, one result per N+1 cycles.
//  Arithmetic, per coefficient: r(x) = (x >= Q) ? x-Q : x, which gives [0,Q) for any W-bit x because Q > 2^(W-1).
//    d = r(a) - r(b) computed W+1 bits wide; result = d<0 ? d+Q : d, always in [0,Q).
//    No truncation beyond W bits occurs.
//  out_coeffs[j] for j>idx are not cleared during FOLD; they hold the prior result until overwritten.
//    Downstream samples only when out_valid is high.
//  Drop rule: prod_valid while in_ready==0 (FOLD, or DONE without out_ready) is ignored, and overflow<=1.
//    The in-flight result is unaffected. overflow is cleared only by reset.
//  Reset mid-FOLD or mid-DONE abandons the result; no out_valid follows until a new accept.
//  busy = (state != IDLE); busy is low during the reset cycle.
// TESTING (N=8, W=8, Q=251)
//  1. cs[0]=5, cs[8]=3; cs[1]=3, cs[9]=5; others 0 -> out[0]=2, out[1]=249, rest 0.
//     out_valid rises exactly 8 cycles after the accept edge.
//  2. cs[2]=255, cs[10]=0; cs[3]=251, cs[11]=250; cs[7]=250 (no partner).
//     -> out[2]=4, out[3]=1, out[7]=250. Check every output is < 251.
//  3. Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_coeffs held constant.
//     Then out_ready=1 -> out_valid drops on the next edge and state returns to IDLE.
//  4. In DONE, pulse prod_valid together with out_ready=1 -> new product accepted with no idle cycle.
//     Second result correct; overflow stays 0.
//  5. Pulse prod_valid at FOLD idx=3 -> pulse dropped, overflow=1 and sticky.
//     The first result is unchanged and correct.
//  6. Assert reset at FOLD idx=5 -> out_valid=0, busy=0, overflow=0, out_coeffs=0 immediately (async).
//     A subsequent product then completes normally.

Source files
------------

// File: rtl/negacyclic_fold_reducer.sv
// Folds a 2N-1 coefficient product modulo x^N+1 and reduces each coefficient into [0,Q).
// Latency: coefficient i written at edge k+1+i after accept edge k; out_valid after edge k+N.
// Backpressure: result held in DONE until out_ready; prod_valid while not ready is dropped (sticky overflow).
module negacyclic_fold_reducer #(
  parameter int MULTIPLIER_WIDTH = 8,
  parameter int INPUT_WIDTH      = 8,
  parameter int MODULUS          = 251
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          prod_valid,
  input  logic [(2*MULTIPLIER_WIDTH-1)*INPUT_WIDTH-1:0] prod_cs,
  output logic                                          in_ready,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       out_coeffs,
  output logic                                          busy,
  output logic                                          overflow
);

  localparam int N  = MULTIPLIER_WIDTH;
  localparam int W  = INPUT_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0] Q_W   = W'(MODULUS);
  localparam logic [W:0]   Q_EXT = (W+1)'(MODULUS);

  // A single conditional subtract only lands in [0,Q) when Q sits above half the W-bit range.
  if ((MODULUS <= (1 << (W-1))) || (MODULUS >= (1 << W))) begin : g_bad_modulus
    $error("negacyclic_fold_reducer: MODULUS must satisfy 2^(W-1) < Q < 2^W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [2*N-2:0][W-1:0]     buf_q, buf_d;
  logic [N-1:0][W-1:0]       out_q, out_d;
  logic                      ovf_q, ovf_d;

  // Top entry c[2N-1] does not exist in the product; pad it with zero so the fold index never leaves range.
  logic [2*N-1:0][W-1:0]     buf_ext;
  logic [IW:0]               hi_idx;
  logic [W-1:0]              lo_red, hi_red, fold_coeff;
  logic [W:0]                diff;

  function automatic logic [W-1:0] red_q(input logic [W-1:0] x);
    return (x >= Q_W) ? (x - Q_W) : x;
  endfunction

  assign buf_ext = {{W{1'b0}}, buf_q};
  assign hi_idx  = {1'b0, idx_q} + (IW+1)'(N);

  // Per-coefficient arithmetic: reduce both halves, subtract one bit wider, add Q back if negative.
  always_comb begin
    lo_red     = red_q(buf_ext[idx_q]);
    hi_red     = red_q(buf_ext[hi_idx]);
    diff       = {1'b0, lo_red} - {1'b0, hi_red};
    fold_coeff = diff[W] ? W'(diff + Q_EXT) : diff[W-1:0];
  end

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign overflow   = ovf_q;
  assign out_coeffs = out_q;

  // Next-state logic: capture on accept, write one folded coefficient per FOLD cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    out_d   = out_q;
    ovf_d   = ovf_q | (prod_valid & ~in_ready);
    case (state_q)
      IDLE: begin
        if (prod_valid) begin
          buf_d   = prod_cs;
          idx_d   = '0;
          state_d = FOLD;
        end
      end
      FOLD: begin
        out_d[idx_q] = fold_coeff;
        if (idx_q == IW'(N-1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (prod_valid) begin
            buf_d   = prod_cs;
            idx_d   = '0;
            state_d = FOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index, capture buffer, result and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_negacyclic_fold_reducer.sv
// Directed bench for negacyclic_fold_reducer with N=8, W=8, Q=251.
// Stimulus driven 1 time unit after each rising edge; outputs sampled at the same point.
// Expected results are hand-computed constants.
module tb_negacyclic_fold_reducer;

  localparam int N = 8;
  localparam int W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  prod_valid;
  logic [2*N-2:0][W-1:0] prod_cs;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0][W-1:0]   out_coeffs;
  logic                  busy;
  logic                  overflow;

  logic [2*N-2:0][W-1:0] pa, pb, pjunk;
  logic [N-1:0][W-1:0]   ea, eb;

  int n_cmp = 0;
  int n_bad = 0;

  negacyclic_fold_reducer #(
    .MULTIPLIER_WIDTH(N),
    .INPUT_WIDTH     (W),
    .MODULUS         (251)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prod_valid(prod_valid),
    .prod_cs   (prod_cs),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeffs(out_coeffs),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    prod_cs    = '0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_cmp++; if (out_coeffs !== '0) begin n_bad++; $display("FAIL reset_coeffs got=%h want=0", out_coeffs); end
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic_fold();
    prod_cs    = pa;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    repeat (7) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_early got=%b want=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_at_n got=%b want=1", out_valid); end
    n_cmp++; if (out_coeffs !== ea) begin n_bad++; $display("FAIL basic_coeffs got=%h want=%h", out_coeffs, ea); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_release got=%b want=0", out_valid); end
  endtask

  task automatic test_modular_edges();
    prod_cs    = pb;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    repeat (8) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL edges_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_coeffs !== eb) begin n_bad++; $display("FAIL edges_coeffs got=%h want=%h", out_coeffs, eb); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (!(out_coeffs[i] < 8'd251)) begin
        n_bad++; $display("FAIL edges_range idx=%0d got=%0d want<251", i, out_coeffs[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", c, out_valid); end
      n_cmp++; if (out_coeffs !== eb) begin n_bad++; $display("FAIL bp_coeffs cyc=%0d got=%h want=%h", c, out_coeffs, eb); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_release_idle got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    prod_cs    = pa;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    repeat (8) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_first_valid got=%b want=1", out_valid); end
    prod_cs    = pb;
    prod_valid = 1'b1;
    out_ready  = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
    tick();
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_no_bubble busy=%b valid=%b want busy=1 valid=0", busy, out_valid);
    end
    repeat (8) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_coeffs !== eb) begin n_bad++; $display("FAIL b2b_second_coeffs got=%h want=%h", out_coeffs, eb); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow got=%b want=0", overflow); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_drop();
    prod_cs    = pa;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    repeat (3) tick();
    prod_cs    = pjunk;
    prod_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL drop_in_ready got=%b want=0", in_ready); end
    tick();
    prod_valid = 1'b0;
    prod_cs    = pa;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drop_overflow got=%b want=1", overflow); end
    repeat (4) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL drop_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_coeffs !== ea) begin n_bad++; $display("FAIL drop_coeffs got=%h want=%h", out_coeffs, ea); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drop_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_reset_mid_fold();
    prod_cs    = pb;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_overflow got=%b want=0", overflow); end
    n_cmp++; if (out_coeffs !== '0) begin n_bad++; $display("FAIL midrst_coeffs got=%h want=0", out_coeffs); end
    tick();
    reset = 1'b0;
    repeat (10) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale_valid got=%b want=0", out_valid); end
    prod_cs    = pa;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    repeat (8) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_after_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_coeffs !== ea) begin n_bad++; $display("FAIL midrst_after_coeffs got=%h want=%h", out_coeffs, ea); end
  endtask

  initial begin
    pa = '0; pa[0] = 8'd5; pa[8] = 8'd3; pa[1] = 8'd3; pa[9] = 8'd5;
    ea = '0; ea[0] = 8'd2; ea[1] = 8'd249;
    pb = '0; pb[2] = 8'd255; pb[10] = 8'd0; pb[3] = 8'd251; pb[11] = 8'd250; pb[7] = 8'd250;
    eb = '0; eb[2] = 8'd4; eb[3] = 8'd1; eb[7] = 8'd250;
    for (int i = 0; i < 2*N-1; i++) pjunk[i] = 8'h11;

    test_reset();
    test_basic_fold();
    test_modular_edges();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid_fold();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
